// File: rtl/dmem_ctrl_pkg.sv
// Shared definitions for the data-memory controller: length/cause codes,
// FSM state encoding and the lane byte-enable helper.
package dmem_ctrl_pkg;

  localparam logic [1:0] ML_BYTE = 2'b00;
  localparam logic [1:0] ML_HALF = 2'b01;
  localparam logic [1:0] ML_WORD = 2'b10;

  localparam logic [1:0] MC_NONE     = 2'b00;
  localparam logic [1:0] MC_MISALIGN = 2'b01;
  localparam logic [1:0] MC_RANGE    = 2'b10;
  localparam logic [1:0] MC_LEN      = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'b00,
    ST_ACCESS = 2'b01,
    ST_RESP   = 2'b10
  } state_t;

  // Byte lanes touched by an access of the given length at byte offset off.
  function automatic logic [3:0] lane_mask(input logic [1:0] len, input logic [1:0] off);
    logic [3:0] m;
    case (len)
      ML_BYTE: m = 4'b0001 << off;
      ML_HALF: m = 4'b0011 << off;
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/dmem_ctrl_ram.sv
// Byte-wide single-port RAM: synchronous write, combinational read.
// Contents are deliberately not reset.
module ram #(
  parameter int DATAW = 8,
  parameter int ADDRW = 10
) (
  input  logic             clk,
  input  logic             we,
  input  logic [ADDRW-1:0] addr,
  input  logic [DATAW-1:0] wdata,
  output logic [DATAW-1:0] rdata
);

  logic [DATAW-1:0] mem [2**ADDRW];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];

endmodule

// File: rtl/dmem_ctrl.sv
// Handshaked data-memory controller: one request in flight, WAIT extra
// access cycles, aligned byte/half/word accesses over four byte lanes.
//
//   state     | meaning
//   ----------+------------------------------------------------------------
//   ST_IDLE   | waiting for req_valid; request fields latched on accept
//   ST_ACCESS | wait counter runs down; at zero, write lanes and capture rsp
//   ST_RESP   | rsp_valid high, rsp_* held until rsp_ready
module dmem_ctrl #(
  parameter int ADDRW = 12,
  parameter int WAIT  = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic        req_sign,
  input  logic [1:0]  req_len,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic [1:0]  rsp_cause
);

  import dmem_ctrl_pkg::*;

  localparam int LANE_AW = ADDRW - 2;

  state_t      state, state_nxt;
  logic [3:0]  cnt, cnt_nxt;

  logic        lat_we;
  logic        lat_sign;
  logic [1:0]  lat_len;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;

  logic [1:0]  off;
  logic [1:0]  cause;
  logic        err_req;
  logic        tc;
  logic        fire;
  logic        accept;
  logic [3:0]  lane_we;
  logic [31:0] wdata_sh;
  logic [31:0] lane_rdata;
  logic [31:0] rd_sh;
  logic [31:0] load_ext;

  assign off    = lat_addr[1:0];
  assign tc     = (cnt == 4'd0);
  assign fire   = (state == ST_ACCESS) && tc;
  assign accept = (state == ST_IDLE) && req_valid;

  // FSM state and wait counter register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
      cnt   <= 4'd0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state and wait-counter logic.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          state_nxt = ST_ACCESS;
          cnt_nxt   = 4'(WAIT);
        end
      end
      ST_ACCESS: begin
        if (tc) state_nxt = ST_RESP;
        else    cnt_nxt   = cnt - 4'd1;
      end
      ST_RESP: begin
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Capture the request on accept; later req_* changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lat_we    <= 1'b0;
      lat_sign  <= 1'b0;
      lat_len   <= ML_BYTE;
      lat_addr  <= 32'd0;
      lat_wdata <= 32'd0;
    end else if (accept) begin
      lat_we    <= req_we;
      lat_sign  <= req_sign;
      lat_len   <= req_len;
      lat_addr  <= req_addr;
      lat_wdata <= req_wdata;
    end
  end

  // Fault classification: illegal length beats misalignment beats range.
  always_comb begin
    cause = MC_NONE;
    if (lat_len == MC_LEN) begin
      cause = MC_LEN;
    end else if ((lat_len == ML_HALF && off[0]) || (lat_len == ML_WORD && off != 2'd0)) begin
      cause = MC_MISALIGN;
    end else if ((lat_addr >> ADDRW) != 32'd0) begin
      cause = MC_RANGE;
    end
  end

  assign err_req  = (cause != MC_NONE);
  assign lane_we  = (fire && lat_we && !err_req) ? lane_mask(lat_len, off) : 4'b0000;
  assign wdata_sh = lat_wdata << {off, 3'b000};

  for (genvar i = 0; i < 4; i++) begin : g_lane
    ram #(
      .DATAW(8),
      .ADDRW(LANE_AW)
    ) u_lane (
      .clk   (clk),
      .we    (lane_we[i]),
      .addr  (lat_addr[ADDRW-1:2]),
      .wdata (wdata_sh[8*i +: 8]),
      .rdata (lane_rdata[8*i +: 8])
    );
  end

  assign rd_sh = lane_rdata >> {off, 3'b000};

  // Load alignment and extension; a word load ignores lat_sign.
  always_comb begin
    load_ext = rd_sh;
    case (lat_len)
      ML_BYTE: load_ext = {{24{lat_sign & rd_sh[7]}}, rd_sh[7:0]};
      ML_HALF: load_ext = {{16{lat_sign & rd_sh[15]}}, rd_sh[15:0]};
      default: load_ext = rd_sh;
    endcase
  end

  // Response registers, loaded once at terminal count and held through RESP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
      rsp_cause <= MC_NONE;
    end else if (fire) begin
      rsp_rdata <= (lat_we || err_req) ? 32'd0 : load_ext;
      rsp_err   <= err_req;
      rsp_cause <= cause;
    end
  end

  assign req_ready = (state == ST_IDLE) && !rst;
  assign rsp_valid = (state == ST_RESP);

endmodule

// File: tb/tb_dmem_ctrl.sv
// Bench for dmem_ctrl: a WAIT=0 instance and a WAIT=3 instance share the
// clock and reset; directed vectors plus handshake-hold and reset-abort cases.
`timescale 1ns/1ps
module tb_dmem_ctrl;

  logic        clk;
  logic        rst;
  logic        req_valid [2];
  logic        req_ready [2];
  logic        req_we    [2];
  logic        req_sign  [2];
  logic [1:0]  req_len   [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        rsp_valid [2];
  logic        rsp_ready [2];
  logic [31:0] rsp_rdata [2];
  logic        rsp_err   [2];
  logic [1:0]  rsp_cause [2];

  int errors = 0;
  int checks = 0;

  dmem_ctrl #(.ADDRW(12), .WAIT(0)) u_w0 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
    .req_sign(req_sign[0]), .req_len(req_len[0]), .req_addr(req_addr[0]),
    .req_wdata(req_wdata[0]), .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]),
    .rsp_rdata(rsp_rdata[0]), .rsp_err(rsp_err[0]), .rsp_cause(rsp_cause[0])
  );

  dmem_ctrl #(.ADDRW(12), .WAIT(3)) u_w3 (
    .clk(clk), .rst(rst),
    .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
    .req_sign(req_sign[1]), .req_len(req_len[1]), .req_addr(req_addr[1]),
    .req_wdata(req_wdata[1]), .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]),
    .rsp_rdata(rsp_rdata[1]), .rsp_err(rsp_err[1]), .rsp_cause(rsp_cause[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int          d;
    logic        we;
    logic        sign;
    logic [1:0]  len;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [1:0]  cause;
  } vec_t;

  localparam int NV = 21;
  vec_t vecs [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One full transaction with rsp_ready held high; lat counts clock edges
  // from accept until rsp_valid is seen (-1 if it never arrives).
  task automatic do_req(input int d, input logic we, input logic sign, input logic [1:0] len,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        output logic [31:0] rd, output logic e, output logic [1:0] c,
                        output int lat);
    int guard;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_we[d]    = we;
    req_sign[d]  = sign;
    req_len[d]   = len;
    req_addr[d]  = addr;
    req_wdata[d] = wdata;
    rsp_ready[d] = 1'b1;
    guard = 0;
    while (!req_ready[d] && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    @(posedge clk);
    #1 req_valid[d] = 1'b0;
    lat = -1;
    rd  = 32'hxxxxxxxx;
    e   = 1'bx;
    c   = 2'bxx;
    for (int k = 1; k <= 40; k++) begin
      @(posedge clk);
      #1;
      if (rsp_valid[d]) begin
        lat = k;
        rd  = rsp_rdata[d];
        e   = rsp_err[d];
        c   = rsp_cause[d];
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] rd;
    logic        e;
    logic [1:0]  c;
    int          lat;

    //          d  we    sign  len    addr          wdata         rdata         err   cause
    vecs[0]  = '{0, 1'b1, 1'b0, 2'b10, 32'h0000_0010, 32'h1122_3344, 32'h0000_0000, 1'b0, 2'b00};
    vecs[1]  = '{0, 1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0,         32'h1122_3344, 1'b0, 2'b00};
    vecs[2]  = '{0, 1'b1, 1'b0, 2'b00, 32'h0000_0013, 32'h0000_00AB, 32'h0000_0000, 1'b0, 2'b00};
    vecs[3]  = '{0, 1'b0, 1'b1, 2'b00, 32'h0000_0013, 32'h0,         32'hFFFF_FFAB, 1'b0, 2'b00};
    vecs[4]  = '{0, 1'b0, 1'b0, 2'b00, 32'h0000_0013, 32'h0,         32'h0000_00AB, 1'b0, 2'b00};
    vecs[5]  = '{0, 1'b0, 1'b0, 2'b10, 32'h0000_0010, 32'h0,         32'hAB22_3344, 1'b0, 2'b00};
    vecs[6]  = '{0, 1'b0, 1'b0, 2'b01, 32'h0000_0011, 32'h0,         32'h0000_0000, 1'b1, 2'b01};
    vecs[7]  = '{0, 1'b0, 1'b1, 2'b01, 32'h0000_0012, 32'h0,         32'hFFFF_AB22, 1'b0, 2'b00};
    vecs[8]  = '{0, 1'b0, 1'b0, 2'b01, 32'h0000_0010, 32'h0,         32'h0000_3344, 1'b0, 2'b00};
    vecs[9]  = '{0, 1'b1, 1'b0, 2'b10, 32'h0000_0000, 32'h5566_7788, 32'h0000_0000, 1'b0, 2'b00};
    vecs[10] = '{0, 1'b1, 1'b0, 2'b10, 32'h0000_1000, 32'hDEAD_BEEF, 32'h0000_0000, 1'b1, 2'b10};
    vecs[11] = '{0, 1'b0, 1'b0, 2'b10, 32'h0000_0000, 32'h0,         32'h5566_7788, 1'b0, 2'b00};
    vecs[12] = '{0, 1'b0, 1'b0, 2'b11, 32'h0000_1001, 32'h0,         32'h0000_0000, 1'b1, 2'b11};
    vecs[13] = '{0, 1'b0, 1'b0, 2'b10, 32'h0000_1002, 32'h0,         32'h0000_0000, 1'b1, 2'b01};
    vecs[14] = '{0, 1'b1, 1'b0, 2'b01, 32'h0000_0012, 32'h0000_BEEF, 32'h0000_0000, 1'b0, 2'b00};
    vecs[15] = '{0, 1'b0, 1'b1, 2'b10, 32'h0000_0010, 32'h0,         32'hBEEF_3344, 1'b0, 2'b00};
    vecs[16] = '{0, 1'b0, 1'b1, 2'b00, 32'h0000_0011, 32'h0,         32'h0000_0033, 1'b0, 2'b00};
    vecs[17] = '{1, 1'b1, 1'b0, 2'b10, 32'h0000_0020, 32'h0BAD_F00D, 32'h0000_0000, 1'b0, 2'b00};
    vecs[18] = '{1, 1'b0, 1'b0, 2'b00, 32'h0000_0022, 32'h0,         32'h0000_00AD, 1'b0, 2'b00};
    vecs[19] = '{1, 1'b0, 1'b1, 2'b01, 32'h0000_0020, 32'h0,         32'hFFFF_F00D, 1'b0, 2'b00};
    vecs[20] = '{1, 1'b0, 1'b0, 2'b01, 32'h0000_0023, 32'h0,         32'h0000_0000, 1'b1, 2'b01};

    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      req_valid[d] = 1'b0;
      req_we[d]    = 1'b0;
      req_sign[d]  = 1'b0;
      req_len[d]   = 2'b00;
      req_addr[d]  = 32'd0;
      req_wdata[d] = 32'd0;
      rsp_ready[d] = 1'b0;
    end

    #1;
    chk("ready_in_reset", 32'(req_ready[0]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_ready", 32'(req_ready[0]), 32'd1);
    chk("reset_valid", 32'(rsp_valid[0]), 32'd0);
    chk("reset_rdata", rsp_rdata[0], 32'd0);
    chk("reset_err",   32'(rsp_err[0]), 32'd0);
    chk("reset_cause", 32'(rsp_cause[0]), 32'd0);

    for (int i = 0; i < NV; i++) begin
      do_req(vecs[i].d, vecs[i].we, vecs[i].sign, vecs[i].len, vecs[i].addr, vecs[i].wdata,
             rd, e, c, lat);
      chk($sformatf("v%0d_latency", i), 32'(lat), (vecs[i].d == 1) ? 32'd4 : 32'd1);
      chk($sformatf("v%0d_rdata", i), rd, vecs[i].rdata);
      chk($sformatf("v%0d_err", i), 32'(e), 32'(vecs[i].err));
      chk($sformatf("v%0d_cause", i), 32'(c), 32'(vecs[i].cause));
    end

    // WAIT=3 load with rsp_ready low: busy through ACCESS, held stable in RESP.
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b0;
    req_sign[1]  = 1'b0;
    req_len[1]   = 2'b10;
    req_addr[1]  = 32'h20;
    rsp_ready[1] = 1'b0;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_valid_c%0d", k), 32'(rsp_valid[1]), (k == 4) ? 32'd1 : 32'd0);
      chk($sformatf("hold_busy_c%0d", k), 32'(req_ready[1]), 32'd0);
    end
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      chk($sformatf("hold_rdata_%0d", k), rsp_rdata[1], 32'h0BAD_F00D);
      chk($sformatf("hold_vstay_%0d", k), 32'(rsp_valid[1]), 32'd1);
      chk($sformatf("hold_rstay_%0d", k), 32'(req_ready[1]), 32'd0);
    end
    rsp_ready[1] = 1'b1;
    @(posedge clk);
    #1;
    chk("release_valid", 32'(rsp_valid[1]), 32'd0);
    chk("release_ready", 32'(req_ready[1]), 32'd1);

    // Reset in the second ACCESS cycle of a WAIT=3 store aborts it.
    @(negedge clk);
    req_valid[1] = 1'b1;
    req_we[1]    = 1'b1;
    req_len[1]   = 2'b10;
    req_addr[1]  = 32'h20;
    req_wdata[1] = 32'h1234_5678;
    @(posedge clk);
    #1 req_valid[1] = 1'b0;
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("abort_ready", 32'(req_ready[1]), 32'd0);
    chk("abort_valid", 32'(rsp_valid[1]), 32'd0);
    chk("abort_rdata", rsp_rdata[1], 32'd0);
    chk("abort_err",   32'(rsp_err[1]), 32'd0);
    chk("abort_cause", 32'(rsp_cause[1]), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("abort_ready_after", 32'(req_ready[1]), 32'd1);
    do_req(1, 1'b0, 1'b0, 2'b10, 32'h20, 32'h0, rd, e, c, lat);
    chk("abort_old_data", rd, 32'h0BAD_F00D);
    chk("abort_old_err",  32'(e), 32'd0);
    chk("abort_latency",  32'(lat), 32'd4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
